// File: rtl/ps2_key_sequencer_pkg.sv
// Shared PS/2 constants and state encodings for the key sequencer.
package ps2_key_sequencer_pkg;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] ASCII_NONE = 8'h00;

  typedef enum logic {H_IDLE, H_GAP} hs_state_e;
  typedef enum logic [1:0] {P_BASE, P_EXT, P_BRK, P_EXT_BRK} parse_state_e;
endpackage

// File: rtl/ps2_key_sequencer_scan2ascii.sv
// Scan-code set 2 to lowercase ASCII lookup: a-z, 0-9, space and enter.
module ps2_scan2ascii
  import ps2_key_sequencer_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = ASCII_NONE;
    case (code)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;
      default: ascii = ASCII_NONE;
    endcase
  end
endmodule

// File: rtl/ps2_key_sequencer.sv
// Drains PS/2 scan bytes from the keyboard FIFO and turns make/break/E0
// sequences into single key events with held-key tracking and a press counter.
module ps2_key_sequencer
  import ps2_key_sequencer_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter bit IGNORE_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  input  logic             clr_err,
  output logic             key_valid,
  output logic             key_make,
  output logic             key_rpt,
  output logic             key_ext,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err
);
  hs_state_e    hs_q, hs_d;
  parse_state_e ps_q, ps_d;
  logic [7:0]       byte_q, byte_d, key_code_q, key_code_d, held_code_q, held_code_d;
  logic             byte_vld_q, byte_vld_d, nextdata_n_q, nextdata_n_d;
  logic             key_valid_q, key_valid_d, key_make_q, key_make_d;
  logic             key_rpt_q, key_rpt_d, key_ext_q, key_ext_d;
  logic             key_down_q, key_down_d, held_ext_q, held_ext_d;
  logic             ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             ev_make, ev_brk, ev_ext, held_match;
  logic [7:0]       rom_ascii;

  // Handshake: a latched byte is popped the following cycle, then one idle gap.
  always_comb begin
    hs_d         = hs_q;
    byte_d       = byte_q;
    byte_vld_d   = 1'b0;
    nextdata_n_d = 1'b1;
    case (hs_q)
      H_IDLE: if (ready) begin
        byte_d       = data;
        byte_vld_d   = 1'b1;
        nextdata_n_d = 1'b0;
        hs_d         = H_GAP;
      end
      default: hs_d = H_IDLE;
    endcase
  end

  always_comb begin
    ps_d    = ps_q;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (byte_vld_q) begin
      case (ps_q)
        P_BASE: begin
          if (byte_q == PS2_EXT)      ps_d = P_EXT;
          else if (byte_q == PS2_BRK) ps_d = P_BRK;
          else                        ev_make = 1'b1;
        end
        P_EXT: begin
          if (byte_q == PS2_BRK)      ps_d = P_EXT_BRK;
          else if (byte_q != PS2_EXT) begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            ps_d    = P_BASE;
          end
        end
        P_BRK: begin
          ps_d   = P_BASE;
          ev_brk = (byte_q != PS2_EXT) && (byte_q != PS2_BRK);
        end
        default: begin
          ps_d   = P_BASE;
          ev_brk = (byte_q != PS2_EXT) && (byte_q != PS2_BRK);
          ev_ext = 1'b1;
        end
      endcase
    end
  end

  // Held key is tracked separately so a break of some other key cannot disturb it.
  assign held_match = key_down_q && ({ev_ext, byte_q} == {held_ext_q, held_code_q});

  always_comb begin
    key_valid_d = 1'b0;
    key_make_d  = key_make_q;
    key_rpt_d   = key_rpt_q;
    key_ext_d   = key_ext_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    press_cnt_d = press_cnt_q;
    if (ev_make && held_match) begin
      if (!IGNORE_REPEAT) begin
        key_valid_d = 1'b1;
        key_make_d  = 1'b1;
        key_rpt_d   = 1'b1;
        key_code_d  = byte_q;
        key_ext_d   = ev_ext;
      end
    end else if (ev_make) begin
      key_valid_d = 1'b1;
      key_make_d  = 1'b1;
      key_rpt_d   = 1'b0;
      key_code_d  = byte_q;
      key_ext_d   = ev_ext;
      key_down_d  = 1'b1;
      held_code_d = byte_q;
      held_ext_d  = ev_ext;
      press_cnt_d = press_cnt_q + CNT_W'(1);
    end else if (ev_brk) begin
      key_valid_d = 1'b1;
      key_make_d  = 1'b0;
      key_rpt_d   = 1'b0;
      key_code_d  = byte_q;
      key_ext_d   = ev_ext;
      if (held_match) key_down_d = 1'b0;
    end
    ovf_err_d = overflow ? 1'b1 : (clr_err ? 1'b0 : ovf_err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= H_IDLE;             ps_q <= P_BASE;
      byte_q <= 8'h00;            byte_vld_q <= 1'b0;
      nextdata_n_q <= 1'b1;       key_valid_q <= 1'b0;
      key_make_q <= 1'b0;         key_rpt_q <= 1'b0;
      key_ext_q <= 1'b0;          key_code_q <= 8'h00;
      key_down_q <= 1'b0;         held_code_q <= 8'h00;
      held_ext_q <= 1'b0;         press_cnt_q <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      hs_q <= hs_d;               ps_q <= ps_d;
      byte_q <= byte_d;           byte_vld_q <= byte_vld_d;
      nextdata_n_q <= nextdata_n_d; key_valid_q <= key_valid_d;
      key_make_q <= key_make_d;   key_rpt_q <= key_rpt_d;
      key_ext_q <= key_ext_d;     key_code_q <= key_code_d;
      key_down_q <= key_down_d;   held_code_q <= held_code_d;
      held_ext_q <= held_ext_d;   press_cnt_q <= press_cnt_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  ps2_scan2ascii u_scan2ascii (.code(key_code_q), .ascii(rom_ascii));

  assign key_ascii  = key_ext_q ? ASCII_NONE : rom_ascii;
  assign nextdata_n = nextdata_n_q;
  assign key_valid  = key_valid_q;
  assign key_make   = key_make_q;
  assign key_rpt    = key_rpt_q;
  assign key_ext    = key_ext_q;
  assign key_code   = key_code_q;
  assign key_down   = key_down_q;
  assign press_cnt  = press_cnt_q;
  assign ovf_err    = ovf_err_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: a FIFO model feeds bytes, expected key events are queued
// as stimulus is issued and a monitor compares them as key_valid pulses appear.
module tb_ps2_key_sequencer;
  logic       clk = 1'b0;
  logic       rst, ready, overflow, clr_err, nextdata_n;
  logic [7:0] data;
  logic       key_valid, key_make, key_rpt, key_ext, key_down, ovf_err;
  logic [7:0] key_code, key_ascii, press_cnt;

  typedef struct packed {
    logic       make;
    logic       rpt;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
    logic       down;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] cnt_m;
  logic       nd_prev_low = 1'b0;

  always #5 clk = ~clk;

  ps2_key_sequencer dut (
    .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .clr_err(clr_err), .key_valid(key_valid),
    .key_make(key_make), .key_rpt(key_rpt), .key_ext(key_ext),
    .key_code(key_code), .key_ascii(key_ascii), .key_down(key_down),
    .press_cnt(press_cnt), .ovf_err(ovf_err)
  );

  // FIFO model of ps2_keyboard: pops on a sampled low nextdata_n.
  initial begin
    ready = 1'b0;
    data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && nextdata_n == 1'b0 && fifo.size() > 0) void'(fifo.pop_front());
      ready = (fifo.size() > 0);
      data  = ready ? fifo[0] : 8'h00;
    end
  end

  // Monitor: pop-strobe shape and scoreboard comparison of every event.
  initial begin
    ev_t e, got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (nextdata_n == 1'b0) begin
          n_tests++;
          if (nd_prev_low) begin
            n_fail++;
            $display("FAIL nextdata_pulse: got low for 2 cycles, required single-cycle low");
          end
        end
        nd_prev_low = (nextdata_n == 1'b0);
        if (key_valid) begin
          got = '{key_make, key_rpt, key_ext, key_code, key_ascii, key_down, press_cnt};
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got code=%02h make=%0b, required no event", key_code, key_make);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL event: got make=%0b rpt=%0b ext=%0b code=%02h ascii=%02h down=%0b cnt=%0d, required make=%0b rpt=%0b ext=%0b code=%02h ascii=%02h down=%0b cnt=%0d",
                       got.make, got.rpt, got.ext, got.code, got.ascii, got.down, got.cnt,
                       e.make, e.rpt, e.ext, e.code, e.ascii, e.down, e.cnt);
            end else begin
              $display("[TB] event make=%0b ext=%0b code=%02h ascii=%02h down=%0b cnt=%0d",
                       got.make, got.ext, got.code, got.ascii, got.down, got.cnt);
            end
          end
        end
      end else begin
        nd_prev_low = 1'b0;
      end
    end
  end

  task automatic expect_ev(input logic mk, input logic ex, input logic [7:0] code,
                           input logic [7:0] asc, input logic dn, input logic [7:0] cnt);
    ev_t e;
    e = '{mk, 1'b0, ex, code, asc, dn, cnt};
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("[TB] check %s = %h", name, got);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int t;
    t = 0;
    while (fifo.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (fifo.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d bytes and %0d events outstanding, required 0 and 0",
               name, fifo.size(), exp_q.size());
      fifo.delete();
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {1'b0, nextdata_n, key_valid, key_make, key_rpt, key_ext, key_code,
            key_ascii, key_down, press_cnt, ovf_err};
  endfunction

  initial begin
    rst = 1'b1; overflow = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 32'h4000_0000);
    rst = 1'b0;

    expect_ev(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, 8'd1);
    send(8'h1C);
    drain("make_1c", 100);

    send(8'h1C); send(8'h1C);
    drain("repeat_1c", 100);
    chk("repeat_cnt",  {24'd0, press_cnt}, 32'd1);
    chk("repeat_down", {31'd0, key_down},  32'd1);

    expect_ev(1'b0, 1'b0, 8'h1C, 8'h61, 1'b0, 8'd1);
    send(8'hF0); send(8'h1C);
    drain("break_1c", 100);

    expect_ev(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, 8'd2);
    expect_ev(1'b0, 1'b0, 8'h15, 8'h71, 1'b1, 8'd2);
    expect_ev(1'b1, 1'b0, 8'h24, 8'h65, 1'b1, 8'd3);
    expect_ev(1'b0, 1'b0, 8'h24, 8'h65, 1'b0, 8'd3);
    send(8'h1C); send(8'hF0); send(8'h15); send(8'h24); send(8'hF0); send(8'h24);
    drain("unheld_break", 200);

    expect_ev(1'b1, 1'b1, 8'h75, 8'h00, 1'b1, 8'd4);
    expect_ev(1'b0, 1'b1, 8'h75, 8'h00, 1'b0, 8'd4);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext_75", 200);

    expect_ev(1'b1, 1'b0, 8'h29, 8'h20, 1'b1, 8'd5);
    expect_ev(1'b0, 1'b0, 8'h29, 8'h20, 1'b0, 8'd5);
    expect_ev(1'b1, 1'b0, 8'h5A, 8'h0D, 1'b1, 8'd6);
    send(8'hF0); send(8'hE0); send(8'h29); send(8'hF0); send(8'h29); send(8'h5A);
    drain("proto_err", 200);

    overflow = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    overflow = 1'b0; clr_err = 1'b0;
    chk("ovf_set_wins", {31'd0, ovf_err}, 32'd1);
    @(negedge clk);
    chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovf_cleared", {31'd0, ovf_err}, 32'd0);

    cnt_m = 8'd6;
    for (int i = 0; i < 256; i++) begin
      cnt_m = cnt_m + 8'd1;
      if (i % 2 == 0) begin
        expect_ev(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, cnt_m);
        send(8'h1C);
      end else begin
        expect_ev(1'b1, 1'b0, 8'h32, 8'h62, 1'b1, cnt_m);
        send(8'h32);
      end
    end
    drain("wrap", 2000);
    chk("wrap_cnt", {24'd0, press_cnt}, 32'd6);

    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    send(8'hF0);
    drain("pre_reset_f0", 100);
    #1 rst = 1'b1;
    #1 chk("async_reset_outputs", out_vec(), 32'h4000_0000);
    @(negedge clk);
    rst = 1'b0;
    expect_ev(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, 8'd1);
    send(8'h1C);
    drain("post_reset_make", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
